// File: rtl/fetch_pkg.sv
// Shared opcode constants and state encoding for the instruction-fetch sequencer.
package fetch_pkg;

  localparam logic [5:0]  OP_JMP   = 6'b110000;
  localparam logic [5:0]  OP_JNE   = 6'b110010;
  localparam logic [5:0]  OP_JNC   = 6'b111000;
  localparam logic [31:0] NOP_INST = 32'h0C42_1000;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_WAIT_BR = 2'd2,
    S_HALT    = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_predecode.sv
// Combinational jump classification and target extraction for a fetched word.
module fetch_predecode
  import fetch_pkg::*;
#(
  parameter int TGT_LSB = 18,
  parameter int TGT_W   = 8
) (
  input  logic [31:0] inst,
  output logic        is_jmp,
  output logic        is_cond,
  output logic [31:0] target
);

  logic [5:0] op;
  logic       unused_inst;

  assign op      = inst[31:26];
  assign is_jmp  = (op == OP_JMP);
  assign is_cond = (op == OP_JNE) || (op == OP_JNC);
  assign target  = {{(32-TGT_W){1'b0}}, inst[TGT_LSB+TGT_W-1:TGT_LSB]};

  // Only the opcode and target field matter here.
  assign unused_inst = ^inst;

endmodule

// File: rtl/fetch_seq.sv
// Fetch sequencer: owns the PC, feeds a one-entry valid/ready output stage,
// resolves JMP locally and parks on conditional jumps until execute resolves them.
module fetch_seq
  import fetch_pkg::*;
#(
  parameter int ROM_DEPTH = 21,
  parameter int TGT_LSB   = 18,
  parameter int TGT_W     = 8
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        start,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_inst,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  input  logic        br_valid,
  input  logic        br_taken,
  output logic        busy,
  output logic        halted
);

  localparam logic [31:0] DEPTH = 32'(ROM_DEPTH);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  tgt_q, tgt_d;
  logic [31:0]  inst_q, inst_d;
  logic [31:0]  ipc_q, ipc_d;
  logic         vld_q, vld_d;
  logic         busy_q, busy_d;
  logic         halted_q, halted_d;

  logic         is_jmp, is_cond;
  logic [31:0]  target;
  logic         xfer, load, past_end;

  fetch_predecode #(
    .TGT_LSB (TGT_LSB),
    .TGT_W   (TGT_W)
  ) u_predecode (
    .inst    (mem_inst),
    .is_jmp  (is_jmp),
    .is_cond (is_cond),
    .target  (target)
  );

  assign past_end = (pc_q >= DEPTH);
  assign xfer     = vld_q && inst_ready;
  assign load     = (state_q == S_RUN) && !past_end && (!vld_q || inst_ready);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    tgt_d   = tgt_q;
    inst_d  = inst_q;
    ipc_d   = ipc_q;
    vld_d   = vld_q;

    // A load in the same cycle re-asserts valid below.
    if (xfer) vld_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          pc_d    = 32'd0;
        end
      end
      S_RUN: begin
        if (past_end) begin
          state_d = S_HALT;
        end else if (load) begin
          inst_d = mem_inst;
          ipc_d  = pc_q;
          vld_d  = 1'b1;
          if (is_jmp) begin
            pc_d = target;
          end else begin
            pc_d = pc_q + 32'd1;
            if (is_cond) begin
              tgt_d   = target;
              state_d = S_WAIT_BR;
            end
          end
        end
      end
      S_WAIT_BR: begin
        if (br_valid) begin
          state_d = S_RUN;
          if (br_taken) pc_d = tgt_q;
        end
      end
      S_HALT: begin
        if (start) begin
          state_d = S_RUN;
          pc_d    = 32'd0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d   = (state_d == S_RUN) || (state_d == S_WAIT_BR);
    halted_d = (state_d == S_HALT);
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q  <= S_IDLE;
      pc_q     <= 32'd0;
      tgt_q    <= 32'd0;
      inst_q   <= NOP_INST;
      ipc_q    <= 32'd0;
      vld_q    <= 1'b0;
      busy_q   <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      tgt_q    <= tgt_d;
      inst_q   <= inst_d;
      ipc_q    <= ipc_d;
      vld_q    <= vld_d;
      busy_q   <= busy_d;
      halted_q <= halted_d;
    end
  end

  assign mem_addr   = pc_q;
  assign inst_out   = inst_q;
  assign inst_pc    = ipc_q;
  assign inst_valid = vld_q;
  assign busy       = busy_q;
  assign halted     = halted_q;

endmodule

// File: tb/tb_fetch_seq.sv
// Scoreboarded bench for fetch_seq: a small program ROM exercises sequential fetch,
// stalls, taken/not-taken conditional jumps, JMP, halt/restart and reset abort.
module tb_fetch_seq;

  localparam logic [5:0]  T_JMP = 6'b110000;
  localparam logic [5:0]  T_JNE = 6'b110010;
  localparam logic [5:0]  T_JNC = 6'b111000;
  localparam logic [31:0] T_NOP = 32'h0C42_1000;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } sb_t;

  logic        clk = 1'b0;
  logic        clrn = 1'b1;
  logic        start = 1'b0;
  logic [31:0] mem_addr;
  logic [31:0] mem_inst;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic        br_valid = 1'b0;
  logic        br_taken = 1'b0;
  logic        busy;
  logic        halted;

  int  checks = 0;
  int  errors = 0;
  sb_t sb[$];

  fetch_seq dut (
    .clk        (clk),
    .clrn       (clrn),
    .start      (start),
    .mem_addr   (mem_addr),
    .mem_inst   (mem_inst),
    .inst_out   (inst_out),
    .inst_pc    (inst_pc),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .br_valid   (br_valid),
    .br_taken   (br_taken),
    .busy       (busy),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  // Program: 8 JNC->0xE, 0xD JMP->0x12, 0x11 JMP->9, 0x13 JNE->2.
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    logic [31:0] w;
    if (a >= 32'd21) begin
      w = T_NOP;
    end else begin
      case (a)
        32'd8:   w = {T_JNC, 8'h0E, 18'h0};
        32'd13:  w = {T_JMP, 8'h12, 18'h0};
        32'd17:  w = {T_JMP, 8'h09, 18'h0};
        32'd19:  w = {T_JNE, 8'h02, 18'h0};
        default: w = 32'h5421_0001 + (a << 8);
      endcase
    end
    return w;
  endfunction

  assign mem_inst = rom_word(mem_addr);

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push_pc(input logic [31:0] p);
    sb_t e;
    e.pc   = p;
    e.inst = rom_word(p);
    sb.push_back(e);
  endtask

  task automatic wait_pc(input logic [31:0] p, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (inst_valid && inst_pc == p) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  // Every transfer seen mid-cycle must match the head of the scoreboard.
  always @(negedge clk) begin
    if (clrn && inst_valid && inst_ready) begin
      sb_t e;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL xfer_unexpected: got pc=%h inst=%h, expected no transfer", inst_pc, inst_out);
      end else begin
        e = sb.pop_front();
        if (inst_pc !== e.pc || inst_out !== e.inst) begin
          errors++;
          $display("FAIL xfer_data: got pc=%h inst=%h, expected pc=%h inst=%h",
                   inst_pc, inst_out, e.pc, e.inst);
        end
      end
    end
  end

  task automatic test_reset();
    #3 clrn = 1'b0;
    tick();
    tick();
    checks += 6;
    if (mem_addr !== 32'd0) begin errors++; $display("FAIL rst_addr: got %h, expected 0", mem_addr); end
    if (inst_out !== T_NOP) begin errors++; $display("FAIL rst_inst: got %h, expected %h", inst_out, T_NOP); end
    if (inst_pc !== 32'd0) begin errors++; $display("FAIL rst_pc: got %h, expected 0", inst_pc); end
    if (inst_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b, expected 0", inst_valid); end
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b, expected 0", busy); end
    if (halted !== 1'b0) begin errors++; $display("FAIL rst_halted: got %b, expected 0", halted); end
    clrn = 1'b1;
    tick();
  endtask

  task automatic test_sequential();
    for (int p = 0; p <= 8; p++) push_pc(32'(p));
    inst_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks += 2;
    if (inst_valid !== 1'b0) begin errors++; $display("FAIL seq_first_lat: valid=%b, expected 0", inst_valid); end
    if (busy !== 1'b1) begin errors++; $display("FAIL seq_busy: got %b, expected 1", busy); end
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (inst_valid !== 1'b1 || inst_pc !== 32'(k)) begin
        errors++;
        $display("FAIL seq_pc%0d: valid=%b pc=%h, expected valid=1 pc=%h", k, inst_valid, inst_pc, k);
      end
      if (k == 0) begin
        checks++;
        if (inst_out !== 32'h5421_0001) begin
          errors++;
          $display("FAIL seq_inst0: got %h, expected 54210001", inst_out);
        end
      end
    end
  endtask

  task automatic test_stall();
    tick();
    tick();
    checks++;
    if (inst_pc !== 32'd5) begin errors++; $display("FAIL stall_pre: pc=%h, expected 5", inst_pc); end
    inst_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (inst_valid !== 1'b1 || inst_pc !== 32'd5 || inst_out !== rom_word(32'd5)) begin
        errors++;
        $display("FAIL stall_hold%0d: valid=%b pc=%h inst=%h, expected 1/5/%h",
                 k, inst_valid, inst_pc, inst_out, rom_word(32'd5));
      end
    end
    inst_ready = 1'b1;
    tick();
    checks++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'd6) begin
      errors++;
      $display("FAIL stall_release: valid=%b pc=%h, expected 1/6", inst_valid, inst_pc);
    end
  endtask

  task automatic test_cond_taken();
    bit ok;
    push_pc(32'hE); push_pc(32'hF); push_pc(32'h10); push_pc(32'h11);
    for (int p = 9; p <= 13; p++) push_pc(32'(p));
    push_pc(32'h12); push_pc(32'h13); push_pc(32'h14);
    wait_pc(32'd8, 10, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL jnc_reach: pc=%h, expected 8", inst_pc); end
    tick();
    checks += 2;
    if (inst_valid !== 1'b0) begin errors++; $display("FAIL jnc_wait_valid: got %b, expected 0", inst_valid); end
    if (busy !== 1'b1) begin errors++; $display("FAIL jnc_wait_busy: got %b, expected 1", busy); end
    br_valid = 1'b1;
    br_taken = 1'b1;
    tick();
    br_valid = 1'b0;
    br_taken = 1'b0;
    checks++;
    if (inst_valid !== 1'b0) begin errors++; $display("FAIL jnc_resolve_valid: got %b, expected 0", inst_valid); end
    tick();
    checks++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'hE) begin
      errors++;
      $display("FAIL jnc_target: valid=%b pc=%h, expected 1/e", inst_valid, inst_pc);
    end
  endtask

  task automatic test_jmp_no_bubble();
    bit ok;
    wait_pc(32'hD, 20, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL jmp_reach: pc=%h, expected d", inst_pc); end
    tick();
    checks++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h12) begin
      errors++;
      $display("FAIL jmp_bubble: valid=%b pc=%h, expected 1/12", inst_valid, inst_pc);
    end
  endtask

  task automatic test_jne_halt_restart();
    bit ok;
    wait_pc(32'h13, 5, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL jne_reach: pc=%h, expected 13", inst_pc); end
    br_valid = 1'b1;
    br_taken = 1'b0;
    tick();
    br_valid = 1'b0;
    checks++;
    if (inst_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL jne_same_cycle: valid=%b busy=%b, expected 0/1", inst_valid, busy);
    end
    tick();
    checks++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h14) begin
      errors++;
      $display("FAIL jne_fallthru: valid=%b pc=%h, expected 1/14", inst_valid, inst_pc);
    end
    tick();
    checks += 2;
    if (inst_valid !== 1'b0 || halted !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL halt_state: valid=%b halted=%b busy=%b, expected 0/1/0", inst_valid, halted, busy);
    end
    if (sb.size() != 0) begin errors++; $display("FAIL halt_sb_left: got %0d, expected 0", sb.size()); end
    push_pc(32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (halted !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL restart_state: halted=%b busy=%b, expected 0/1", halted, busy);
    end
    tick();
    checks++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'd0) begin
      errors++;
      $display("FAIL restart_pc: valid=%b pc=%h, expected 1/0", inst_valid, inst_pc);
    end
  endtask

  task automatic test_reset_in_wait();
    bit ok;
    for (int p = 1; p <= 7; p++) push_pc(32'(p));
    wait_pc(32'd8, 20, ok);
    inst_ready = 1'b0;
    tick();
    checks++;
    if (!ok || inst_valid !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL wait_setup: ok=%b valid=%b busy=%b, expected 1/1/1", ok, inst_valid, busy);
    end
    #1 clrn = 1'b0;
    #1;
    checks += 3;
    if (inst_valid !== 1'b0 || busy !== 1'b0 || halted !== 1'b0) begin
      errors++;
      $display("FAIL arst_flags: valid=%b busy=%b halted=%b, expected 0/0/0", inst_valid, busy, halted);
    end
    if (inst_out !== T_NOP || inst_pc !== 32'd0 || mem_addr !== 32'd0) begin
      errors++;
      $display("FAIL arst_data: inst=%h pc=%h addr=%h, expected %h/0/0", inst_out, inst_pc, mem_addr, T_NOP);
    end
    if (sb.size() != 0) begin errors++; $display("FAIL arst_sb_left: got %0d, expected 0", sb.size()); end
    #1 clrn = 1'b1;
    br_valid = 1'b1;
    br_taken = 1'b1;
    inst_ready = 1'b1;
    tick();
    tick();
    br_valid = 1'b0;
    br_taken = 1'b0;
    checks++;
    if (mem_addr !== 32'd0 || inst_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL post_rst_br: addr=%h valid=%b busy=%b, expected 0/0/0", mem_addr, inst_valid, busy);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_cond_taken();
    test_jmp_no_bubble();
    test_jne_halt_restart();
    test_reset_in_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
